// File: rtl/escalonador_pkg.sv
// Shared types for the process scheduler: slot states, FSM states and the
// id-width helper used to size process ids.
package escalonador_pkg;

    typedef enum logic [1:0] {
        LIVRE  = 2'd0,
        PRONTO = 2'd1,
        ATIVO  = 2'd2
    } slot_t;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        TROCA  = 2'd1,
        EXEC   = 2'd2
    } fsm_t;

    // Width of a process id; never less than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/escalonador_processos_if.sv
// Controller <-> scheduler <-> program counter signal bundle.
// master: controller / PC side, slave: the scheduler.
interface escalonador_processos_if #(
    parameter int PC_WIDTH = 16,
    parameter int ID_W     = 2
);
    logic                avanca;
    logic                criar;
    logic [PC_WIDTH-1:0] criar_pc;
    logic                criar_ok;
    logic                criar_erro;
    logic [ID_W-1:0]     criar_id;
    logic                encerrar;
    logic [PC_WIDTH-1:0] pc_atual;
    logic                troca;
    logic [PC_WIDTH-1:0] pc_novo;
    logic [ID_W-1:0]     processo;
    logic                executando;
    logic [ID_W:0]       ativos;

    modport master (
        output avanca, criar, criar_pc, encerrar, pc_atual,
        input  criar_ok, criar_erro, criar_id, troca, pc_novo,
               processo, executando, ativos
    );

    modport slave (
        input  avanca, criar, criar_pc, encerrar, pc_atual,
        output criar_ok, criar_erro, criar_id, troca, pc_novo,
               processo, executando, ativos
    );
endinterface

// File: rtl/escalonador_processos_seletor_rr.sv
// Rotating priority picker: first set bit of mask scanning upward from
// inicio with wrap-around. Purely combinational.
module seletor_rr #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] inicio,
    output logic         achou,
    output logic [W-1:0] indice
);
    // Scan from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        achou  = 1'b0;
        indice = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[(int'(inicio) + i) % N]) begin
                achou  = 1'b1;
                indice = W'((int'(inicio) + i) % N);
            end
        end
    end
endmodule

// File: rtl/escalonador_processos.sv
// Round-robin preemptive process scheduler. Keeps N_PROC slots with saved
// PCs and drives one-cycle PC load pulses on every context switch.
module escalonador_processos
    import escalonador_pkg::*;
#(
    parameter int N_PROC   = 4,
    parameter int PC_WIDTH = 16,
    parameter int QUANTUM  = 16,
    parameter int ID_W     = id_width(N_PROC)
) (
    input  logic clk,
    input  logic reset,
    escalonador_processos_if.slave bus
);
    localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    slot_t               estado   [N_PROC];
    logic [PC_WIDTH-1:0] pc_salvo [N_PROC];
    fsm_t                fsm;
    logic [ID_W-1:0]     processo_r;
    logic [CW-1:0]       cont;
    logic                criar_ok_r;
    logic                criar_erro_r;
    logic [ID_W-1:0]     criar_id_r;

    logic [N_PROC-1:0]   mask_pronto;
    logic [N_PROC-1:0]   mask_livre;
    logic [ID_W-1:0]     inicio_rr;
    logic                rr_achou;
    logic [ID_W-1:0]     rr_idx;
    logic                livre_achou;
    logic [ID_W-1:0]     livre_idx;
    logic [ID_W:0]       n_ativos;
    logic                expira;

    // Slot masks and occupancy count, all from registered slot state.
    always_comb begin
        mask_pronto = '0;
        mask_livre  = '0;
        n_ativos    = '0;
        for (int i = 0; i < N_PROC; i++) begin
            mask_pronto[i] = (estado[i] == PRONTO);
            mask_livre[i]  = (estado[i] == LIVRE);
            if (estado[i] != LIVRE)
                n_ativos = n_ativos + (ID_W+1)'(1);
        end
    end

    // Round-robin search starts just after the current/last process.
    assign inicio_rr = (processo_r == ID_W'(N_PROC - 1)) ? '0 : processo_r + 1'b1;
    assign expira    = bus.avanca && (cont == CW'(QUANTUM - 1));

    seletor_rr #(.N(N_PROC), .W(ID_W)) u_rr (
        .mask   (mask_pronto),
        .inicio (inicio_rr),
        .achou  (rr_achou),
        .indice (rr_idx)
    );

    seletor_rr #(.N(N_PROC), .W(ID_W)) u_livre (
        .mask   (mask_livre),
        .inicio ('0),
        .achou  (livre_achou),
        .indice (livre_idx)
    );

    // Scheduler FSM, slot states and saved PCs (including slot creation).
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= OCIOSO;
            processo_r <= '0;
            cont       <= '0;
            for (int i = 0; i < N_PROC; i++) begin
                estado[i]   <= LIVRE;
                pc_salvo[i] <= '0;
            end
        end else begin
            case (fsm)
                OCIOSO: begin
                    if (rr_achou) begin
                        processo_r <= rr_idx;
                        fsm        <= TROCA;
                    end
                end
                TROCA: begin
                    estado[processo_r] <= ATIVO;
                    cont               <= '0;
                    fsm                <= EXEC;
                end
                EXEC: begin
                    if (bus.encerrar) begin
                        // Halt wins over expiry; the PC is discarded.
                        estado[processo_r] <= LIVRE;
                        if (rr_achou) begin
                            processo_r <= rr_idx;
                            fsm        <= TROCA;
                        end else begin
                            fsm <= OCIOSO;
                        end
                    end else if (expira) begin
                        if (rr_achou) begin
                            pc_salvo[processo_r] <= bus.pc_atual;
                            estado[processo_r]   <= PRONTO;
                            processo_r           <= rr_idx;
                            fsm                  <= TROCA;
                        end else begin
                            // Nobody waiting: keep running, restart quantum.
                            cont <= '0;
                        end
                    end else if (bus.avanca) begin
                        cont <= cont + 1'b1;
                    end
                end
                default: fsm <= OCIOSO;
            endcase
            // A free slot is never the running one, so no write conflict.
            if (bus.criar && livre_achou) begin
                estado[livre_idx]   <= PRONTO;
                pc_salvo[livre_idx] <= bus.criar_pc;
            end
        end
    end

    // Creation handshake pulses, one cycle after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            criar_ok_r   <= 1'b0;
            criar_erro_r <= 1'b0;
            criar_id_r   <= '0;
        end else begin
            criar_ok_r   <= bus.criar && livre_achou;
            criar_erro_r <= bus.criar && !livre_achou;
            criar_id_r   <= (bus.criar && livre_achou) ? livre_idx : '0;
        end
    end

    assign bus.criar_ok   = criar_ok_r;
    assign bus.criar_erro = criar_erro_r;
    assign bus.criar_id   = criar_id_r;
    assign bus.troca      = (fsm == TROCA);
    assign bus.pc_novo    = (fsm == TROCA) ? pc_salvo[processo_r] : '0;
    assign bus.processo   = processo_r;
    assign bus.executando = (fsm != OCIOSO);
    assign bus.ativos     = n_ativos;
endmodule

// File: tb/tb_escalonador_processos.sv
// Directed bench for the process scheduler, N_PROC=4, QUANTUM=4.
module tb_escalonador_processos;
    localparam int N_PROC   = 4;
    localparam int PC_WIDTH = 16;
    localparam int QUANTUM  = 4;
    localparam int ID_W     = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_troca;

    escalonador_processos_if #(.PC_WIDTH(PC_WIDTH), .ID_W(ID_W)) bus ();

    escalonador_processos #(
        .N_PROC(N_PROC), .PC_WIDTH(PC_WIDTH), .QUANTUM(QUANTUM), .ID_W(ID_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.avanca   = 1'b0;
        bus.criar    = 1'b0;
        bus.criar_pc = '0;
        bus.encerrar = 1'b0;
        bus.pc_atual = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic criar_um(input logic [15:0] pc);
        bus.criar    = 1'b1;
        bus.criar_pc = pc;
        tick();
        bus.criar    = 1'b0;
    endtask

    // One full quantum of retired instructions.
    task automatic quantum(input logic [15:0] pc);
        bus.avanca   = 1'b1;
        bus.pc_atual = pc;
        repeat (QUANTUM) tick();
        bus.avanca   = 1'b0;
    endtask

    function automatic logic [31:0] saidas();
        return {5'b0, bus.troca, bus.pc_novo, bus.processo, bus.executando,
                bus.ativos, bus.criar_ok, bus.criar_erro, bus.criar_id};
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_outputs", saidas(), 32'h0);
        reset = 1'b0;

        // 1: first creation and first load
        criar_um(16'h0010);
        chk("t1_criar_ok", 32'(bus.criar_ok), 32'd1);
        chk("t1_criar_id", 32'(bus.criar_id), 32'd0);
        tick();
        chk("t1_troca", 32'(bus.troca), 32'd1);
        chk("t1_pc_novo", 32'(bus.pc_novo), 32'h10);
        chk("t1_processo", 32'(bus.processo), 32'd0);
        chk("t1_executando", 32'(bus.executando), 32'd1);

        // 2: round-robin across three processes
        do_reset();
        criar_um(16'h0010);
        criar_um(16'h0020);
        criar_um(16'h0030);
        chk("t2_ativos", 32'(bus.ativos), 32'd3);
        quantum(16'h0014);
        chk("t2_troca_a", 32'(bus.troca), 32'd1);
        chk("t2_proc_a", 32'(bus.processo), 32'd1);
        chk("t2_pc_a", 32'(bus.pc_novo), 32'h20);
        tick();
        quantum(16'h0024);
        chk("t2_proc_b", 32'(bus.processo), 32'd2);
        chk("t2_pc_b", 32'(bus.pc_novo), 32'h30);
        tick();
        quantum(16'h0034);
        chk("t2_troca_c", 32'(bus.troca), 32'd1);
        chk("t2_proc_c", 32'(bus.processo), 32'd0);
        chk("t2_pc_c", 32'(bus.pc_novo), 32'h14);

        // 3: lone process is never preempted
        do_reset();
        criar_um(16'h0100);
        tick();
        tick();
        n_troca = 0;
        bus.avanca = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.pc_atual = 16'(16'h0100 + i);
            tick();
            if (bus.troca) n_troca++;
        end
        bus.avanca = 1'b0;
        chk("t3_no_troca", 32'(n_troca), 32'd0);
        chk("t3_executando", 32'(bus.executando), 32'd1);

        // 4: full table, error, halt, slot reuse
        do_reset();
        criar_um(16'h0010);
        criar_um(16'h0020);
        criar_um(16'h0030);
        criar_um(16'h0040);
        chk("t4_id3", 32'(bus.criar_id), 32'd3);
        criar_um(16'h0050);
        chk("t4_erro", 32'(bus.criar_erro), 32'd1);
        chk("t4_ok_low", 32'(bus.criar_ok), 32'd0);
        chk("t4_ativos4", 32'(bus.ativos), 32'd4);
        bus.encerrar = 1'b1;
        tick();
        bus.encerrar = 1'b0;
        chk("t4_troca", 32'(bus.troca), 32'd1);
        chk("t4_proc1", 32'(bus.processo), 32'd1);
        chk("t4_pc", 32'(bus.pc_novo), 32'h20);
        chk("t4_ativos3", 32'(bus.ativos), 32'd3);
        criar_um(16'h0060);
        chk("t4_reuse_ok", 32'(bus.criar_ok), 32'd1);
        chk("t4_reuse_id", 32'(bus.criar_id), 32'd0);

        // 5: halt coinciding with expiry, then last process halts
        do_reset();
        criar_um(16'h0010);
        criar_um(16'h0020);
        tick();
        bus.avanca   = 1'b1;
        bus.pc_atual = 16'h0014;
        repeat (QUANTUM - 1) tick();
        bus.encerrar = 1'b1;
        tick();
        bus.avanca   = 1'b0;
        bus.encerrar = 1'b0;
        chk("t5_troca", 32'(bus.troca), 32'd1);
        chk("t5_proc", 32'(bus.processo), 32'd1);
        chk("t5_pc", 32'(bus.pc_novo), 32'h20);
        chk("t5_ativos1", 32'(bus.ativos), 32'd1);
        tick();
        bus.encerrar = 1'b1;
        tick();
        bus.encerrar = 1'b0;
        chk("t5_exec_off", 32'(bus.executando), 32'd0);
        chk("t5_ativos0", 32'(bus.ativos), 32'd0);
        tick();
        chk("t5_no_troca", 32'(bus.troca), 32'd0);

        // 6: reset during EXEC discards everything
        do_reset();
        criar_um(16'h0010);
        criar_um(16'h0020);
        criar_um(16'h0030);
        bus.avanca   = 1'b1;
        bus.pc_atual = 16'h0012;
        tick();
        bus.avanca   = 1'b0;
        chk("t6_pre_ativos", 32'(bus.ativos), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_reset_outputs", saidas(), 32'h0);
        criar_um(16'h0070);
        chk("t6_ok", 32'(bus.criar_ok), 32'd1);
        chk("t6_id", 32'(bus.criar_id), 32'd0);
        chk("t6_ativos", 32'(bus.ativos), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/escalonador_processos.md
Name: escalonador_processos

Overview:
- Parametrised successor to the single-process program counter and process register used by the processor top level.
- Holds N_PROC process slots, each with a saved PC, and runs them round-robin with a preemptive instruction quantum.
- On each context switch it issues a one-cycle load pulse, the new PC and the new process id to the program counter and instruction memory.
- Sits between the controller (create and halt strobes, instruction-retired strobe) and the program counter.

Parameters:
- N_PROC, 4: number of process slots (≥2).
- PC_WIDTH, 16: PC width.
- QUANTUM, 16: instructions retired before preemption (≥1).
- ID_W, $clog2(N_PROC): process id width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- avanca  in  1  one instruction retired by the running process this cycle.
- criar  in  1  request to create a process.
- criar_pc  in  PC_WIDTH  start PC of the new process.
- criar_ok  out  1  one-cycle pulse: creation accepted.
- criar_erro  out  1  one-cycle pulse: no free slot.
- criar_id  out  ID_W  slot granted; valid while criar_ok is high.
- encerrar  in  1  running process executed halt.
- pc_atual  in  PC_WIDTH  current PC of the running process, saved on preemption.
- troca  out  1  one-cycle pulse: load pc_novo into the PC.
- pc_novo  out  PC_WIDTH  PC to load; valid while troca is high.
- processo  out  ID_W  id of the running or last-run process.
- executando  out  1  a process owns the CPU.
- ativos  out  ID_W+1  count of non-free slots.

Behaviour:
Reset:
- Every slot LIVRE, saved PCs 0, FSM OCIOSO, quantum counter 0.
- All outputs 0.
- Reset asserted mid-operation discards every process in the same cycle.

Slot states and FSM:
- Slot states: LIVRE, PRONTO, ATIVO.
- FSM states: OCIOSO, TROCA, EXEC.

Create:
- When criar=1 and a LIVRE slot exists, the lowest-index LIVRE slot becomes PRONTO with pc=criar_pc.
- Next cycle: criar_ok=1 and criar_id=slot.
- When no slot is free: next cycle criar_erro=1 and the slot state is unchanged.
- The free-slot search uses registered state, so a slot freed by encerrar in the same cycle is not reusable until the following cycle.

OCIOSO:
- executando=0.
- If any slot is PRONTO (registered state), select the next ready slot round-robin from processo+1 with wrap, then go to TROCA.

TROCA (exactly one cycle):
- troca=1, pc_novo=saved pc of the selected slot, processo=selected.
- The slot becomes ATIVO and the counter clears.
- avanca and encerrar are ignored in this cycle.
- Next state EXEC.

EXEC:
- executando=1.
- Each cycle with avanca=1 increments the counter.
- Encerrar: the running slot becomes LIVRE.
  - If another slot is PRONTO, select it round-robin and go to TROCA.
  - Otherwise go to OCIOSO.
- Quantum expiry (avanca=1 with counter=QUANTUM-1):
  - If another slot is PRONTO: save pc_atual into the running slot, mark it PRONTO, select the next ready slot round-robin from processo+1 and go to TROCA.
  - If no other slot is PRONTO: stay in EXEC, clear the counter, no troca pulse, no save.
- encerrar and expiry in the same cycle: encerrar wins and no PC is saved.

Other rules:
- Round-robin selection never picks the slot being preempted while another PRONTO slot exists.
- criar may coincide with any state. A process created during EXEC waits for the next expiry or encerrar.
- ativos counts PRONTO+ATIVO slots and updates one cycle after each event.
- Latency from encerrar or expiry to troca is 1 cycle. From OCIOSO with a ready slot it is 1 cycle.

Decomposition:
- Package escalonador_pkg:
  - slot-state enum (LIVRE/PRONTO/ATIVO);
  - FSM enum (OCIOSO/TROCA/EXEC);
  - function giving the id width from N_PROC.
- Sub-module seletor_rr: combinational rotating priority picker.
  - Inputs: ready mask, start index.
  - Outputs: found flag, index.
  - Instantiated once for round-robin selection; the lowest-free search reuses it with start index 0.

Test Plan (N_PROC=4, QUANTUM=4):
1. Reset, then criar with criar_pc=0x0010 -> criar_ok, criar_id=0; one cycle later troca=1, pc_novo=0x0010, processo=0, executando=1.
2. Create slots 0, 1, 2 (PCs 0x10, 0x20, 0x30), then give 4 avanca with pc_atual=0x0014 -> troca to processo=1 with pc_novo=0x20. After 4 more avanca -> processo=2. After 4 more -> processo=0 with pc_novo=0x0014.
3. Single process, 12 avanca -> no troca after the initial load; executando stays 1.
4. Fill all 4 slots, then criar -> criar_erro=1 and ativos=4. Then encerrar while running slot 0 -> troca to slot 1, ativos=3; the next criar gets criar_id=0.
5. encerrar coinciding with the 4th avanca, another slot ready -> slot freed, no PC saved, switch to the next slot. The last process halts -> OCIOSO, executando=0, ativos=0.
6. reset asserted during EXEC with 3 active processes -> next cycle every output is 0 and a criar is granted id 0.
